rsa_out_collector: RTL and testbench

Parametrised output-drain stage for the systolic array. Replaces the per-row tri-state output bus with X row result FIFOs and a muxed valid/ready drain. The block accepts results shifted out of the left PE column, one channel per row. It streams the full X×Y result matrix in row-major or column-major (transposed) order, with backpressure, a last-beat marker and per-row overflow flags.

---
 rtl/rsa_pkg.sv | 14 +
 rtl/rsa_row_fifo.sv | 59 +++++
 rtl/rsa_out_collector.sv | 140 ++++++++++++++
 tb/tb_rsa_out_collector.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rsa_pkg.sv
// Shared types for the systolic-array output drain: drain FSM states and
// the scan-order constants sampled with start.
package rsa_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    FLUSH = 2'd2
  } drain_state_t;

  localparam logic ROW_MAJOR = 1'b0;
  localparam logic COL_MAJOR = 1'b1;

endpackage

// File: rtl/rsa_row_fifo.sv
// First-word-fall-through row FIFO. A write to a full FIFO is dropped
// (flagged on ovf) unless a pop frees a slot in the same cycle.
module rsa_row_fifo
  import rsa_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int DEPTH      = 4,
  parameter int ADDR_WIDTH = 2
) (
  input  logic             clk,
  input  logic             sys_rst,
  input  logic             wr_en,
  input  logic             rd_en,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic             ovf
);

  logic [WIDTH-1:0]      mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [ADDR_WIDTH:0]   count;
  logic                  wr_ok;
  logic                  rd_ok;

  function automatic logic [ADDR_WIDTH-1:0] next_ptr(input logic [ADDR_WIDTH-1:0] p);
    return (p == ADDR_WIDTH'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full  = (count == (ADDR_WIDTH + 1)'(DEPTH));
  assign empty = (count == '0);
  assign rd_ok = rd_en && !empty;
  assign wr_ok = wr_en && (!full || rd_ok);
  assign ovf   = wr_en && full && !rd_ok;
  assign dout  = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (sys_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_ok) wr_ptr <= next_ptr(wr_ptr);
      if (rd_ok) rd_ptr <= next_ptr(rd_ptr);
      case ({wr_ok, rd_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/rsa_out_collector.sv
// Output drain for the systolic array: X row FIFOs feeding one registered
// valid/ready stream in row-major or column-major order.
module rsa_out_collector
  import rsa_pkg::*;
#(
  parameter int X          = 3,
  parameter int Y          = 3,
  parameter int OUT_LEN    = 8,
  parameter int DEPTH      = 4,
  parameter int ADDR_WIDTH = 2
) (
  input  logic                 clk,
  input  logic                 sys_rst,
  input  logic [X-1:0]         row_val,
  input  logic [X*OUT_LEN-1:0] row_data,
  input  logic                 start,
  input  logic                 mode_col,
  input  logic                 clr_err,
  output logic                 out_val,
  output logic [OUT_LEN-1:0]   out_data,
  output logic                 out_last,
  input  logic                 out_rdy,
  output logic                 busy,
  output logic                 done,
  output logic [X-1:0]         ovf_err
);

  localparam int RW = (X > 1) ? $clog2(X) : 1;
  localparam int CW = (Y > 1) ? $clog2(Y) : 1;
  localparam int BW = (X * Y > 1) ? $clog2(X * Y) : 1;

  drain_state_t        state;
  drain_state_t        state_next;
  logic                mode_q;
  logic [RW-1:0]       row_sel;
  logic [CW-1:0]       col_sel;
  logic [BW-1:0]       beat_cnt;
  logic [X-1:0]        fifo_empty;
  logic [X-1:0]        fifo_full;
  logic [X-1:0]        fifo_ovf;
  logic [X-1:0]        fifo_rd;
  logic [OUT_LEN-1:0]  fifo_dout [X];
  logic                pop;
  logic                last_pop;

  for (genvar i = 0; i < X; i++) begin : g_row
    assign fifo_rd[i] = pop && (row_sel == RW'(i));
    rsa_row_fifo #(
      .WIDTH      (OUT_LEN),
      .DEPTH      (DEPTH),
      .ADDR_WIDTH (ADDR_WIDTH)
    ) u_fifo (
      .clk     (clk),
      .sys_rst (sys_rst),
      .wr_en   (row_val[i]),
      .rd_en   (fifo_rd[i]),
      .din     (row_data[OUT_LEN*i +: OUT_LEN]),
      .dout    (fifo_dout[i]),
      .full    (fifo_full[i]),
      .empty   (fifo_empty[i]),
      .ovf     (fifo_ovf[i])
    );
  end

  // Only the row under the index may feed the output; an empty row stalls the drain.
  assign pop      = (state == DRAIN) && (!out_val || out_rdy) && !fifo_empty[row_sel];
  assign last_pop = pop && (beat_cnt == BW'(X * Y - 1));
  assign busy     = (state != IDLE);

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = DRAIN;
      DRAIN:   if (last_pop) state_next = FLUSH;
      FLUSH:   if (out_val && out_rdy) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Indices are kept zero-based internally and wrap so they always address a real row.
  always_ff @(posedge clk) begin
    if (sys_rst) begin
      state    <= IDLE;
      mode_q   <= ROW_MAJOR;
      row_sel  <= '0;
      col_sel  <= '0;
      beat_cnt <= '0;
      out_val  <= 1'b0;
      out_data <= '0;
      out_last <= 1'b0;
      done     <= 1'b0;
    end else begin
      state <= state_next;
      done  <= (state == FLUSH) && out_val && out_rdy;
      if ((state == IDLE) && start) begin
        mode_q   <= mode_col;
        row_sel  <= '0;
        col_sel  <= '0;
        beat_cnt <= '0;
      end else if (pop) begin
        beat_cnt <= beat_cnt + 1'b1;
        if (mode_q == COL_MAJOR) begin
          if (row_sel == RW'(X - 1)) begin
            row_sel <= '0;
            col_sel <= (col_sel == CW'(Y - 1)) ? '0 : col_sel + 1'b1;
          end else begin
            row_sel <= row_sel + 1'b1;
          end
        end else begin
          if (col_sel == CW'(Y - 1)) begin
            col_sel <= '0;
            row_sel <= (row_sel == RW'(X - 1)) ? '0 : row_sel + 1'b1;
          end else begin
            col_sel <= col_sel + 1'b1;
          end
        end
      end
      if (pop) begin
        out_val  <= 1'b1;
        out_data <= fifo_dout[row_sel];
        out_last <= last_pop;
      end else if (out_rdy) begin
        out_val  <= 1'b0;
        out_last <= 1'b0;
      end
    end
  end

  // clr_err has priority over a same-cycle overflow.
  always_ff @(posedge clk) begin
    if (sys_rst) begin
      ovf_err <= '0;
    end else begin
      assert (!(|(fifo_ovf & ~fifo_full)));
      if (clr_err) ovf_err <= '0;
      else         ovf_err <= ovf_err | fifo_ovf;
    end
  end

endmodule

// File: tb/tb_rsa_out_collector.sv
// Directed bench for rsa_out_collector: a scoreboard queue holds the expected
// beat stream and every handshake is compared against its head.
module tb_rsa_out_collector;

  localparam int X          = 3;
  localparam int Y          = 3;
  localparam int OUT_LEN    = 8;
  localparam int DEPTH      = 4;
  localparam int ADDR_WIDTH = 2;

  logic                 clk = 1'b0;
  logic                 sys_rst;
  logic [X-1:0]         row_val;
  logic [X*OUT_LEN-1:0] row_data;
  logic                 start;
  logic                 mode_col;
  logic                 clr_err;
  logic                 out_val;
  logic [OUT_LEN-1:0]   out_data;
  logic                 out_last;
  logic                 out_rdy;
  logic                 busy;
  logic                 done;
  logic [X-1:0]         ovf_err;

  typedef struct {
    logic [7:0] data;
    logic       last;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   cyc0;

  rsa_out_collector #(
    .X(X), .Y(Y), .OUT_LEN(OUT_LEN), .DEPTH(DEPTH), .ADDR_WIDTH(ADDR_WIDTH)
  ) dut (
    .clk(clk), .sys_rst(sys_rst), .row_val(row_val), .row_data(row_data),
    .start(start), .mode_col(mode_col), .clr_err(clr_err),
    .out_val(out_val), .out_data(out_data), .out_last(out_last),
    .out_rdy(out_rdy), .busy(busy), .done(done), .ovf_err(ovf_err)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkEq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Compare any handshake about to happen at the next edge, then advance one cycle.
  task automatic checkOutput();
    exp_t e;
    if (out_val && out_rdy) begin
      if (sb.size() == 0) begin
        checkEq("extra_beat", 32'(out_val), 32'd0);
      end else begin
        e = sb.pop_front();
        checkEq("beat_data", 32'(out_data), 32'(e.data));
        checkEq("beat_last", 32'(out_last), 32'(e.last));
      end
    end else if (out_val && sb.size() > 0) begin
      checkEq("stall_data", 32'(out_data), 32'(sb[0].data));
    end
    @(negedge clk);
    cyc++;
  endtask

  task automatic applyStimulus(input logic [X-1:0] v, input logic [X*OUT_LEN-1:0] d);
    row_val  = v;
    row_data = d;
    checkOutput();
    row_val  = '0;
  endtask

  function automatic logic [7:0] word(input int r, input int c);
    return 8'((r << 4) | c);
  endfunction

  task automatic pushExp(input logic [7:0] d, input logic l);
    sb.push_back('{d, l});
  endtask

  task automatic pushMatrix(input logic col);
    if (!col) begin
      for (int r = 1; r <= X; r++)
        for (int c = 1; c <= Y; c++) pushExp(word(r, c), (r == X) && (c == Y));
    end else begin
      for (int c = 1; c <= Y; c++)
        for (int r = 1; r <= X; r++) pushExp(word(r, c), (r == X) && (c == Y));
    end
  endtask

  task automatic prefill(input logic [X-1:0] mask);
    logic [X*OUT_LEN-1:0] d;
    for (int c = 1; c <= Y; c++) begin
      d = '0;
      for (int r = 1; r <= X; r++) d[OUT_LEN*(r-1) +: OUT_LEN] = word(r, c);
      applyStimulus(mask, d);
    end
  endtask

  task automatic startDrain(input logic col);
    start    = 1'b1;
    mode_col = col;
    checkOutput();
    start    = 1'b0;
    mode_col = 1'b0;
    checkEq("busy_after_start", 32'(busy), 32'd1);
  endtask

  task automatic runDrain(input logic toggle, input int remain);
    int n = 0;
    while (sb.size() > remain && n < 200) begin
      out_rdy = toggle ? (n % 2 == 0) : 1'b1;
      checkOutput();
      n++;
    end
    checkEq("drain_progress", 32'(sb.size()), 32'(remain));
  endtask

  task automatic checkDone();
    checkEq("done_pulse", 32'(done), 32'd1);
    checkEq("busy_fall", 32'(busy), 32'd0);
    checkOutput();
    checkEq("done_once", 32'(done), 32'd0);
  endtask

  task automatic checkResetValues();
    checkEq("rst_out_val", 32'(out_val), 32'd0);
    checkEq("rst_out_data", 32'(out_data), 32'd0);
    checkEq("rst_out_last", 32'(out_last), 32'd0);
    checkEq("rst_busy", 32'(busy), 32'd0);
    checkEq("rst_done", 32'(done), 32'd0);
    checkEq("rst_ovf_err", 32'(ovf_err), 32'd0);
  endtask

  task automatic doReset();
    sb.delete();
    sys_rst = 1'b1;
    row_val = '0;
    start   = 1'b0;
    clr_err = 1'b0;
    out_rdy = 1'b0;
    checkOutput();
    sys_rst = 1'b0;
  endtask

  initial begin
    sys_rst  = 1'b1;
    row_val  = '0;
    row_data = '0;
    start    = 1'b0;
    mode_col = 1'b0;
    clr_err  = 1'b0;
    out_rdy  = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checkResetValues();
    sys_rst = 1'b0;

    $display("[TB] row-major drain");
    pushMatrix(1'b0);
    prefill('1);
    out_rdy = 1'b1;
    startDrain(1'b0);
    checkEq("first_out_val", 32'(out_val), 32'd0);
    cyc0 = cyc;
    runDrain(1'b0, 0);
    checkEq("throughput_cycles", 32'(cyc - cyc0), 32'd10);
    checkDone();

    $display("[TB] column-major drain");
    pushMatrix(1'b1);
    prefill('1);
    startDrain(1'b1);
    runDrain(1'b0, 0);
    checkDone();

    $display("[TB] backpressure drain with ignored start");
    pushMatrix(1'b0);
    prefill('1);
    startDrain(1'b0);
    start    = 1'b1;
    mode_col = 1'b1;
    checkOutput();
    start    = 1'b0;
    mode_col = 1'b0;
    runDrain(1'b1, 0);
    checkDone();

    $display("[TB] underflow");
    doReset();
    out_rdy = 1'b1;
    for (int c = 1; c <= Y; c++) pushExp(word(1, c), 1'b0);
    prefill(3'b001);
    startDrain(1'b0);
    runDrain(1'b0, 0);
    checkEq("underflow_val", 32'(out_val), 32'd0);
    checkEq("underflow_busy", 32'(busy), 32'd1);
    checkOutput();
    checkOutput();
    checkEq("underflow_wait_val", 32'(out_val), 32'd0);
    for (int r = 2; r <= X; r++)
      for (int c = 1; c <= Y; c++) pushExp(word(r, c), (r == X) && (c == Y));
    prefill(3'b010);
    prefill(3'b100);
    runDrain(1'b0, 0);
    checkDone();

    $display("[TB] overflow");
    doReset();
    out_rdy = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      applyStimulus(3'b001, {16'h0, 8'(8'hA0 | k)});
      if (k == 4) checkEq("ovf_not_yet", 32'(ovf_err), 32'd0);
    end
    checkEq("ovf_set", 32'(ovf_err), 32'b001);
    pushExp(8'hA1, 1'b0);
    pushExp(8'hA2, 1'b0);
    pushExp(8'hA3, 1'b0);
    for (int r = 2; r <= X; r++)
      for (int c = 1; c <= Y; c++) pushExp(word(r, c), (r == X) && (c == Y));
    prefill(3'b110);
    startDrain(1'b0);
    runDrain(1'b0, 0);
    checkDone();
    checkEq("ovf_sticky", 32'(ovf_err), 32'b001);
    clr_err = 1'b1;
    checkOutput();
    clr_err = 1'b0;
    checkEq("ovf_clear", 32'(ovf_err), 32'd0);

    $display("[TB] leftover word drained column-major");
    pushExp(8'hA4, 1'b0);       pushExp(word(2, 1), 1'b0); pushExp(word(3, 1), 1'b0);
    pushExp(8'hB1, 1'b0);       pushExp(word(2, 2), 1'b0); pushExp(word(3, 2), 1'b0);
    pushExp(8'hB2, 1'b0);       pushExp(word(2, 3), 1'b0); pushExp(word(3, 3), 1'b1);
    applyStimulus(3'b111, {word(3, 1), word(2, 1), 8'hB1});
    applyStimulus(3'b111, {word(3, 2), word(2, 2), 8'hB2});
    applyStimulus(3'b110, {word(3, 3), word(2, 3), 8'h00});
    startDrain(1'b1);
    runDrain(1'b0, 0);
    checkDone();

    $display("[TB] reset mid-drain");
    doReset();
    out_rdy = 1'b1;
    pushMatrix(1'b0);
    prefill('1);
    startDrain(1'b0);
    runDrain(1'b0, 5);
    out_rdy = 1'b0;
    sys_rst = 1'b1;
    checkOutput();
    checkResetValues();
    sys_rst = 1'b0;
    sb.delete();
    out_rdy = 1'b1;
    startDrain(1'b0);
    for (int k = 0; k < 5; k++) begin
      checkOutput();
      checkEq("no_val_after_reset", 32'(out_val), 32'd0);
    end
    checkEq("busy_waiting", 32'(busy), 32'd1);
    pushMatrix(1'b0);
    prefill('1);
    runDrain(1'b0, 0);
    checkDone();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
